// File: rtl/cache_wb_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_wb_buffer_if
// Brief    : Eviction, memory-write and lookup channels of the write-back buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface cache_wb_buffer_if #(
  parameter int LINE_BYTES = 64,
  parameter int BEAT_BYTES = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 2
);
  localparam int c_CNT_W = $clog2(DEPTH + 1);

  // eviction side
  logic                      evict_valid_i;
  logic                      evict_ready_o;
  logic [ADDR_WIDTH-1:0]     evict_addr_i;
  logic [LINE_BYTES*8-1:0]   evict_line_i;

  // memory write channel
  logic                      mem_wvalid_o;
  logic                      mem_wready_i;
  logic [ADDR_WIDTH-1:0]     mem_waddr_o;
  logic [BEAT_BYTES*8-1:0]   mem_wdata_o;
  logic                      mem_wlast_o;
  logic                      mem_bvalid_i;

  // refill lookup and status
  logic [ADDR_WIDTH-1:0]     lookup_addr_i;
  logic                      lookup_hit_o;
  logic [c_CNT_W-1:0]        count_o;
  logic                      empty_o;

  modport slave (
    input  evict_valid_i, evict_addr_i, evict_line_i,
    input  mem_wready_i, mem_bvalid_i, lookup_addr_i,
    output evict_ready_o, mem_wvalid_o, mem_waddr_o, mem_wdata_o, mem_wlast_o,
    output lookup_hit_o, count_o, empty_o
  );

  modport master (
    output evict_valid_i, evict_addr_i, evict_line_i,
    output mem_wready_i, mem_bvalid_i, lookup_addr_i,
    input  evict_ready_o, mem_wvalid_o, mem_waddr_o, mem_wdata_o, mem_wlast_o,
    input  lookup_hit_o, count_o, empty_o
  );
endinterface
`default_nettype wire

// File: rtl/cache_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : cache_wb_buffer
// Brief    : FIFO of evicted lines drained to memory as beat bursts, retired on
//            write acknowledge; flags buffered line addresses for the refill path.
// Revision : 1.0 - initial release
// ============================================================================
module cache_wb_buffer #(
  parameter int LINE_BYTES = 64,
  parameter int BEAT_BYTES = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  wire logic        clk_i,
  input  wire logic        rst_i,
  cache_wb_buffer_if.slave bus
);
  localparam int c_BEATS    = LINE_BYTES / BEAT_BYTES;
  localparam int c_LINE_OFF = $clog2(LINE_BYTES);
  localparam int c_BEAT_SH  = $clog2(BEAT_BYTES);
  localparam int c_TAG_W    = ADDR_WIDTH - c_LINE_OFF;
  localparam int c_LINE_W   = LINE_BYTES * 8;
  localparam int c_BEAT_W   = BEAT_BYTES * 8;
  localparam int c_BCNT_W   = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
  localparam int c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W    = $clog2(DEPTH + 1);

  localparam logic [c_CNT_W-1:0]  c_FULL      = c_CNT_W'(DEPTH);
  localparam logic [c_BCNT_W-1:0] c_LAST_BEAT = c_BCNT_W'(c_BEATS - 1);
  localparam logic [c_PTR_W-1:0]  c_PTR_MAX   = c_PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SEND     = 2'd1,
    S_WAIT_ACK = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_BCNT_W-1:0]   r_beat;
  logic [c_BCNT_W-1:0]   w_beat_nxt;

  logic [c_TAG_W-1:0]    r_tag  [DEPTH];
  logic [c_LINE_W-1:0]   r_line [DEPTH];
  logic [DEPTH-1:0]      r_occ;
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_CNT_W-1:0]    r_count;
  logic [c_CNT_W-1:0]    w_count_nxt;
  logic                  r_ready;
  logic                  r_empty;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_send;
  logic                  w_hs;
  logic                  w_last;
  logic [c_TAG_W-1:0]    w_evict_tag;
  logic [c_TAG_W-1:0]    w_lookup_tag;
  logic [DEPTH-1:0]      w_hit_vec;
  logic [c_LINE_W-1:0]   w_head_line;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [ADDR_WIDTH-1:0] w_beat_off;
  logic [c_BEAT_W-1:0]   w_beat_data;
  logic                  w_unused;

  function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  assign w_push       = bus.evict_valid_i & r_ready;
  assign w_pop        = (r_state == S_WAIT_ACK) & bus.mem_bvalid_i;
  assign w_send       = (r_state == S_SEND);
  assign w_hs         = w_send & bus.mem_wready_i;
  assign w_last       = (r_beat == c_LAST_BEAT);
  assign w_evict_tag  = c_TAG_W'(bus.evict_addr_i >> c_LINE_OFF);
  assign w_lookup_tag = c_TAG_W'(bus.lookup_addr_i >> c_LINE_OFF);

  // Offset bits below the line boundary are intentionally dropped.
  assign w_unused = ^{bus.evict_addr_i, bus.lookup_addr_i};

  // ------------------------------------------------------------------------
  // Drain FSM
  // ------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    case (r_state)
      S_IDLE: begin
        if (!r_empty) begin
          w_state_nxt = S_SEND;
          w_beat_nxt  = '0;
        end
      end
      S_SEND: begin
        if (w_hs) begin
          if (w_last) begin
            w_state_nxt = S_WAIT_ACK;
          end else begin
            w_beat_nxt = r_beat + 1'b1;
          end
        end
      end
      S_WAIT_ACK: begin
        if (bus.mem_bvalid_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Ready and empty are registered from the next count, so a pop while full
  // only reopens the eviction port on the following cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_beat   <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
      r_empty  <= 1'b1;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != c_FULL);
      r_empty <= (w_count_nxt == '0);
      if (w_push) begin
        r_wr_ptr        <= f_ptr_inc(r_wr_ptr);
        r_occ[r_wr_ptr] <= 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr        <= f_ptr_inc(r_rd_ptr);
        r_occ[r_rd_ptr] <= 1'b0;
      end
    end
  end

  // Payload storage carries no reset; occupancy bits qualify every use.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_tag[r_wr_ptr]  <= w_evict_tag;
      r_line[r_wr_ptr] <= bus.evict_line_i;
    end
  end

  // ------------------------------------------------------------------------
  // Lookup across every occupied entry, including the one being drained
  // ------------------------------------------------------------------------
  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_lookup
      assign w_hit_vec[g] = r_occ[g] & (r_tag[g] == w_lookup_tag);
    end
  endgenerate

  assign bus.lookup_hit_o = |w_hit_vec;

  // ------------------------------------------------------------------------
  // Beat formation from the head entry
  // ------------------------------------------------------------------------
  assign w_head_line = r_line[r_rd_ptr];
  assign w_head_addr = ADDR_WIDTH'(r_tag[r_rd_ptr]) << c_LINE_OFF;
  assign w_beat_off  = ADDR_WIDTH'(r_beat) << c_BEAT_SH;
  assign w_beat_data = w_head_line[r_beat * c_BEAT_W +: c_BEAT_W];

  assign bus.mem_wvalid_o = w_send;
  assign bus.mem_waddr_o  = w_send ? (w_head_addr + w_beat_off) : '0;
  assign bus.mem_wdata_o  = w_send ? w_beat_data : '0;
  assign bus.mem_wlast_o  = w_send & w_last;

  assign bus.evict_ready_o = r_ready;
  assign bus.count_o       = r_count;
  assign bus.empty_o       = r_empty;

endmodule
`default_nettype wire

// File: tb/tb_cache_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_wb_buffer
// Brief    : Scoreboard bench for cache_wb_buffer with directed eviction vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_wb_buffer;
  localparam int LINE_BYTES = 64;
  localparam int BEAT_BYTES = 8;
  localparam int ADDR_WIDTH = 32;
  localparam int DEPTH      = 2;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic  clk_i = 1'b0;
  logic  rst_i = 1'b1;
  beat_t exp_q[$];
  beat_t mon_e;
  int    total  = 0;
  int    bad    = 0;
  int    hs_cnt = 0;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr;
  logic [63:0] prev_data;
  logic        prev_last;

  always #5 clk_i = ~clk_i;

  cache_wb_buffer_if #(
    .LINE_BYTES(LINE_BYTES), .BEAT_BYTES(BEAT_BYTES),
    .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)
  ) bus ();

  cache_wb_buffer #(
    .LINE_BYTES(LINE_BYTES), .BEAT_BYTES(BEAT_BYTES),
    .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [511:0] make_line(input logic [7:0] base);
    logic [511:0] l;
    for (int i = 0; i < 64; i++) l[i*8 +: 8] = base + 8'(i);
    return l;
  endfunction

  // Expected beats built byte by byte: beat k holds line bytes 8k..8k+7.
  task automatic expect_line(input logic [31:0] addr, input logic [7:0] base);
    beat_t b;
    for (int k = 0; k < 8; k++) begin
      b.addr = {addr[31:6], 6'd0} + 32'(k * 8);
      for (int j = 0; j < 8; j++) b.data[j*8 +: 8] = base + 8'(k * 8 + j);
      b.last = (k == 7);
      exp_q.push_back(b);
    end
  endtask

  task automatic offer(input logic [31:0] addr, input logic [7:0] base);
    bus.evict_valid_i = 1'b1;
    bus.evict_addr_i  = addr;
    bus.evict_line_i  = make_line(base);
  endtask

  task automatic probe(input string name, input logic [31:0] addr, input logic exp);
    bus.lookup_addr_i = addr;
    #1;
    chk(name, bus.lookup_hit_o, exp);
  endtask

  // Returns one cycle after the last beat is accepted (buffer in WAIT_ACK).
  task automatic wait_last(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (bus.mem_wvalid_o && bus.mem_wready_i && bus.mem_wlast_o) begin
        @(posedge clk_i);
        #1;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL %s: no final beat within 100 cycles", name);
  endtask

  task automatic ack();
    bus.mem_bvalid_i = 1'b1;
    tick();
    bus.mem_bvalid_i = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every accepted beat and checks stall stability.
  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", bus.mem_wvalid_o, 1'b1);
        chk("stall_addr",  bus.mem_waddr_o, prev_addr);
        chk("stall_data",  bus.mem_wdata_o, prev_data);
        chk("stall_last",  bus.mem_wlast_o, prev_last);
      end
      if (bus.mem_wvalid_o && bus.mem_wready_i) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got addr 0x%0h expected no beat", bus.mem_waddr_o);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_addr", bus.mem_waddr_o, mon_e.addr);
          chk("beat_data", bus.mem_wdata_o, mon_e.data);
          chk("beat_last", bus.mem_wlast_o, mon_e.last);
        end
      end
      prev_stall = bus.mem_wvalid_o && !bus.mem_wready_i;
      prev_addr  = bus.mem_waddr_o;
      prev_data  = bus.mem_wdata_o;
      prev_last  = bus.mem_wlast_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int start;
    int seen;
    bus.evict_valid_i = 1'b0;
    bus.evict_addr_i  = '0;
    bus.evict_line_i  = '0;
    bus.mem_wready_i  = 1'b0;
    bus.mem_bvalid_i  = 1'b0;
    bus.lookup_addr_i = '0;

    // ---- reset state ----
    tick();
    tick();
    chk("rst_count", bus.count_o, 0);
    chk("rst_empty", bus.empty_o, 1);
    chk("rst_ready", bus.evict_ready_o, 1);
    chk("rst_wvalid", bus.mem_wvalid_o, 0);
    chk("rst_wlast", bus.mem_wlast_o, 0);
    chk("rst_waddr", bus.mem_waddr_o, 0);
    chk("rst_wdata", bus.mem_wdata_o, 0);
    chk("rst_hit", bus.lookup_hit_o, 0);
    rst_i = 1'b0;
    tick();

    // ---- single line ----
    bus.mem_wready_i = 1'b1;
    offer(32'h0000_1040, 8'h00);
    expect_line(32'h0000_1040, 8'h00);
    tick();
    bus.evict_valid_i = 1'b0;
    chk("t1_count", bus.count_o, 1);
    chk("t1_empty", bus.empty_o, 0);
    chk("t1_no_beat_yet", bus.mem_wvalid_o, 0);
    probe("t1_hit", 32'h0000_1044, 1'b1);
    tick();
    chk("t1_first_valid", bus.mem_wvalid_o, 1);
    chk("t1_first_addr", bus.mem_waddr_o, 32'h0000_1040);
    chk("t1_first_data", bus.mem_wdata_o, 64'h0706050403020100);
    chk("t1_first_last", bus.mem_wlast_o, 0);
    wait_last("t1_drain");
    chk("t1_wait_valid", bus.mem_wvalid_o, 0);
    tick();
    tick();
    chk("t1_wait_count", bus.count_o, 1);
    ack();
    chk("t1_empty_after_ack", bus.empty_o, 1);
    chk("t1_count_after_ack", bus.count_o, 0);
    probe("t1_hit_after_ack", 32'h0000_1044, 1'b0);

    // ---- stray acks and backpressure ----
    bus.mem_wready_i = 1'b0;
    offer(32'h0000_8000, 8'h20);
    expect_line(32'h0000_8000, 8'h20);
    tick();
    bus.evict_valid_i = 1'b0;
    bus.mem_bvalid_i  = 1'b1;
    tick();
    chk("stray_idle_count", bus.count_o, 1);
    tick();
    bus.mem_bvalid_i = 1'b0;
    chk("stray_send_count", bus.count_o, 1);
    chk("bp_valid", bus.mem_wvalid_o, 1);
    start = hs_cnt;
    for (int i = 0; i < 16; i++) begin
      bus.mem_wready_i = ((i % 2) == 0);
      tick();
    end
    chk("bp_handshakes", 64'(hs_cnt - start), 8);
    chk("bp_wait_valid", bus.mem_wvalid_o, 0);
    ack();
    chk("bp_count_after_ack", bus.count_o, 0);

    // ---- full, ordering, lookup, simultaneous push/pop ----
    offer(32'h0000_2000, 8'h40);
    expect_line(32'h0000_2000, 8'h40);
    tick();
    offer(32'h0000_3000, 8'h80);
    expect_line(32'h0000_3000, 8'h80);
    tick();
    chk("full_ready", bus.evict_ready_o, 0);
    chk("full_count", bus.count_o, 2);
    offer(32'h0000_4000, 8'hC0);
    probe("lk_send_hit", 32'h0000_2024, 1'b1);
    probe("lk_next_line", 32'h0000_2040, 1'b0);
    probe("lk_second_hit", 32'h0000_3010, 1'b1);
    tick();
    tick();
    chk("held_count", bus.count_o, 2);
    chk("held_ready", bus.evict_ready_o, 0);
    bus.mem_wready_i = 1'b1;
    wait_last("full_drain_a");
    probe("lk_wait_hit", 32'h0000_2024, 1'b1);
    probe("lk_wait_next_line", 32'h0000_2040, 1'b0);
    chk("wait_ready", bus.evict_ready_o, 0);
    ack();
    chk("pop_ready", bus.evict_ready_o, 1);
    chk("pop_count", bus.count_o, 1);
    probe("lk_after_pop", 32'h0000_2024, 1'b0);
    expect_line(32'h0000_4000, 8'hC0);
    tick();
    bus.evict_valid_i = 1'b0;
    chk("third_accepted", bus.count_o, 2);
    wait_last("full_drain_b");
    ack();
    chk("b_pop_count", bus.count_o, 1);
    wait_last("full_drain_c");
    offer(32'h0000_5000, 8'h11);
    expect_line(32'h0000_5000, 8'h11);
    bus.mem_bvalid_i = 1'b1;
    tick();
    bus.evict_valid_i = 1'b0;
    bus.mem_bvalid_i  = 1'b0;
    chk("simul_count", bus.count_o, 1);
    probe("simul_popped_miss", 32'h0000_4000, 1'b0);
    probe("simul_pushed_hit", 32'h0000_5000, 1'b1);
    wait_last("simul_drain_d");
    ack();
    chk("simul_empty", bus.empty_o, 1);

    // ---- reset mid-burst ----
    offer(32'h0000_6000, 8'h33);
    expect_line(32'h0000_6000, 8'h33);
    tick();
    bus.evict_valid_i = 1'b0;
    start = hs_cnt;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      #1;
      if (hs_cnt - start >= 4) break;
    end
    chk("mid_beats_before_reset", 64'(hs_cnt - start), 4);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    bus.lookup_addr_i = 32'h0000_6000;
    #1;
    chk("mid_rst_wvalid", bus.mem_wvalid_o, 0);
    chk("mid_rst_count", bus.count_o, 0);
    chk("mid_rst_empty", bus.empty_o, 1);
    chk("mid_rst_hit", bus.lookup_hit_o, 0);
    exp_q.delete();
    tick();
    tick();
    rst_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.mem_wvalid_o) seen++;
    end
    chk("post_rst_no_beats", 64'(seen), 0);

    // ---- recovery after reset ----
    offer(32'h0000_7000, 8'h99);
    expect_line(32'h0000_7000, 8'h99);
    tick();
    bus.evict_valid_i = 1'b0;
    wait_last("recover_drain");
    ack();
    chk("recover_empty", bus.empty_o, 1);
    chk("scoreboard_drained", 64'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_wb_buffer.md
# cache_wb_buffer

Write-back buffer between the cache replacement logic and the memory write port. It captures lines chosen for eviction, together with their line address, into a small FIFO. It then drains each line to memory as a burst of fixed-width beats over a valid/ready write channel and retires the entry on a memory write acknowledge. A lookup port flags a line address that still sits in the buffer, so the refill path can stall instead of reading stale memory.

## Interface
- LINE_BYTES, 64, bytes per cache line (power of two)
- BEAT_BYTES, 8, bytes per memory write beat (power of two, divides LINE_BYTES); BEATS = LINE_BYTES/BEAT_BYTES
- ADDR_WIDTH, 32, byte address width
- DEPTH, 2, number of buffered lines (≥1)

Ports:
- clk_i  in  1  the single clock
- rst_i  in  1  asynchronous, active-high reset
- evict_valid_i  in  1  evicted line offered
- evict_ready_o  out  1  buffer can accept (count < DEPTH)
- evict_addr_i  in  ADDR_WIDTH  line byte address; low $clog2(LINE_BYTES) bits ignored
- evict_line_i  in  LINE_BYTES*8  line data, byte 0 in bits [7:0]
- mem_wvalid_o  out  1  beat valid
- mem_wready_i  in  1  memory accepts beat
- mem_waddr_o  out  ADDR_WIDTH  byte address of current beat
- mem_wdata_o  out  BEAT_BYTES*8  beat data
- mem_wlast_o  out  1  final beat of line
- mem_bvalid_i  in  1  write acknowledge for the line just sent
- lookup_addr_i  in  ADDR_WIDTH  address probed by the refill path
- lookup_hit_o  out  1  probed line is in the buffer (combinational)
- count_o  out  $clog2(DEPTH+1)  occupied entries
- empty_o  out  1  count_o == 0

## Operation
- Enqueue occurs when evict_valid_i && evict_ready_o at a rising edge. The entry stores the line address with low bits forced to 0 and the full line data. Entries are FIFO ordered.
- Drain FSM states: IDLE, SEND, WAIT_ACK.
  - IDLE → SEND when the FIFO is non-empty. The beat counter is cleared.
  - SEND: mem_wvalid_o=1. Data is head line bits [beat*BEAT_BYTES*8 +: BEAT_BYTES*8]. Address is head_addr + beat*BEAT_BYTES. mem_wlast_o=1 when beat==BEATS-1.
  - In SEND, a handshake (mem_wvalid_o && mem_wready_i) increments the beat counter. A handshake on the last beat moves the FSM to WAIT_ACK.
  - WAIT_ACK: mem_wvalid_o=0. When mem_bvalid_i=1, the head entry is popped and the FSM goes to IDLE.
- mem_bvalid_i is ignored outside WAIT_ACK.
- While mem_wvalid_o=1 && mem_wready_i=0, addr, data and last stay stable.
- lookup_hit_o=1 if any occupied entry's line address equals lookup_addr_i[ADDR_WIDTH-1:$clog2(LINE_BYTES)]. This includes the head entry in SEND and WAIT_ACK. A hit clears only when that entry pops.
- Enqueue and pop in the same cycle: count_o is unchanged and both take effect.
- Full: evict_ready_o=0. A pop in the same cycle does not bypass, so ready rises the following cycle.
- Duplicate addresses are not merged. Both entries drain in order.
- No counter or pointer wraps incorrectly: pointers wrap modulo DEPTH, and the beat counter is $clog2(BEATS) bits wide, or 1 bit when BEATS=1.

## Timing
- Reset (asynchronous, takes effect immediately) puts the block in this state:
  - FIFO emptied; FSM in IDLE; beat counter 0.
  - count_o=0, empty_o=1, evict_ready_o=1.
  - mem_wvalid_o=0, mem_wlast_o=0, mem_waddr_o=0, mem_wdata_o=0.
  - lookup_hit_o=0.
- Reset mid-burst drops all entries, including the partially sent line. No further beats are issued.
- Enqueue at edge N has these effects:
  - count_o and empty_o update after edge N.
  - lookup_hit_o can hit from cycle N+1.
  - The first beat is valid at cycle N+2 at the earliest (IDLE→SEND takes one cycle).
- With mem_wready_i held at 1, a line needs BEATS consecutive cycles in SEND.
- mem_bvalid_i seen at edge M pops at edge M. The next entry's first beat is valid at M+2.
- count_o, empty_o and evict_ready_o are registered state. lookup_hit_o is combinational from lookup_addr_i.

## Test plan
- **Single line:** with mem_wready_i=1, enqueue addr 0x0000_1040 and line bytes i=0..63 equal to i.
  - Beats 0..7 carry addresses 0x1040, 0x1048, …, 0x1078 and data 0x0706050403020100, …, 0x3F3E3D3C3B3A3938.
  - wlast is 1 only on beat 7.
  - mem_bvalid_i 3 cycles later → empty_o=1.
- **Backpressure:** toggle mem_wready_i 1/0 each cycle → each beat is held stable while stalled. 8 handshakes occur in 16 cycles, with no duplicated or skipped beat.
- **Full and ordering:** enqueue 0x2000, then 0x3000 → evict_ready_o=0 and count_o=2.
  - A third offer is held off until the first bvalid, then accepted the next cycle.
  - Memory sees the 0x2000 line, then 0x3000, then the third line.
- **Lookup:** probe 0x2024 while 0x2000 is in SEND or WAIT_ACK → lookup_hit_o=1. After bvalid, the hit is 0. Probing 0x2040 gives 0 throughout.
- **Stray ack and simultaneous events:**
  - mem_bvalid_i pulsed in IDLE or SEND → no pop.
  - Enqueue in the same cycle as the pop with count_o=1 → count_o stays 1.
- **Reset mid-burst:** assert rst_i after beat 3 → mem_wvalid_o drops immediately, count_o=0, lookup_hit_o=0. After release, no beats are issued until a new enqueue.
